// File: rtl/text_buffer_writer.sv
// Character-cell screen memory and cursor engine for the VGA text pipeline.
// Consumes a character stream, maintains the cursor and serves cell lookups.
module text_buffer_writer #(
  parameter int         ROW_NUMBER = 15,
  parameter int         COL_NUMBER = 40,
  parameter logic [7:0] BLANK_ID   = 8'h20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_char_in,
  input  logic       i_char_valid,
  output logic       o_char_ready,
  input  logic [3:0] i_char_row,
  input  logic [5:0] i_char_col,
  output logic [7:0] o_character_id,
  output logic [3:0] o_cursor_row,
  output logic [5:0] o_cursor_col
);

  // state          | meaning
  // S_CLEAR        | blank every cell, one per cycle, cursor held at (0,0)
  // S_IDLE         | accept and interpret characters
  // S_SCROLL_COPY  | shift rows 1..14 up by one row
  // S_SCROLL_BLANK | blank the bottom row, then back to idle
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCROLL_COPY, S_SCROLL_BLANK} state_t;

  localparam int         CELLS     = ROW_NUMBER * COL_NUMBER;
  localparam logic [9:0] LAST_CELL = 10'(CELLS - 1);
  localparam logic [9:0] LAST_COPY = 10'(CELLS - COL_NUMBER - 1);
  localparam logic [9:0] COLS10    = 10'(COL_NUMBER);
  localparam logic [3:0] LAST_ROW  = 4'(ROW_NUMBER - 1);
  localparam logic [5:0] LAST_COL  = 6'(COL_NUMBER - 1);

  logic [7:0] r_mem [0:CELLS-1];
  state_t     r_state;
  logic [9:0] r_idx;
  logic [3:0] r_row;
  logic [5:0] r_col;

  state_t     w_state_nxt;
  logic [9:0] w_idx_nxt;
  logic [3:0] w_row_nxt;
  logic [5:0] w_col_nxt;
  logic       w_we;
  logic [9:0] w_waddr;
  logic [7:0] w_wdata;
  logic       w_adv;
  logic [9:0] w_cur_addr;
  logic [9:0] w_rd_addr;
  logic [7:0] w_copy_data;
  logic       w_printable;

  assign w_cur_addr  = {6'd0, r_row} * COLS10 + {4'd0, r_col};
  assign w_rd_addr   = {6'd0, i_char_row} * COLS10 + {4'd0, i_char_col};
  assign w_copy_data = r_mem[r_idx + COLS10];
  assign w_printable = (i_char_in >= 8'h20) && (i_char_in <= 8'h7E);

  assign o_character_id = ((i_char_row < 4'(ROW_NUMBER)) && (i_char_col < 6'(COL_NUMBER)))
                          ? r_mem[w_rd_addr] : BLANK_ID;
  assign o_char_ready   = (r_state == S_IDLE);
  assign o_cursor_row   = r_row;
  assign o_cursor_col   = r_col;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_we        = 1'b0;
    w_waddr     = r_idx;
    w_wdata     = BLANK_ID;
    w_adv       = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_we      = 1'b1;
        w_row_nxt = 4'd0;
        w_col_nxt = 6'd0;
        if (r_idx == LAST_CELL) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 10'd0;
        end else begin
          w_idx_nxt = r_idx + 10'd1;
        end
      end
      S_IDLE: begin
        if (i_char_valid) begin
          if (w_printable) begin
            w_we    = 1'b1;
            w_waddr = w_cur_addr;
            w_wdata = i_char_in;
            if (r_col == LAST_COL) begin
              w_col_nxt = 6'd0;
              w_adv     = 1'b1;
            end else begin
              w_col_nxt = r_col + 6'd1;
            end
          end else begin
            case (i_char_in)
              8'h0A: begin
                w_col_nxt = 6'd0;
                w_adv     = 1'b1;
              end
              8'h0D: w_col_nxt = 6'd0;
              8'h08: begin
                // backspace never wraps to the previous row
                if (r_col != 6'd0) begin
                  w_col_nxt = r_col - 6'd1;
                  w_we      = 1'b1;
                  w_waddr   = w_cur_addr - 10'd1;
                end
              end
              8'h0C: begin
                w_state_nxt = S_CLEAR;
                w_idx_nxt   = 10'd0;
                w_row_nxt   = 4'd0;
                w_col_nxt   = 6'd0;
              end
              default: ;
            endcase
          end
          if (w_adv) begin
            if (r_row == LAST_ROW) begin
              w_state_nxt = S_SCROLL_COPY;
              w_idx_nxt   = 10'd0;
            end else begin
              w_row_nxt = r_row + 4'd1;
            end
          end
        end
      end
      S_SCROLL_COPY: begin
        w_we    = 1'b1;
        w_wdata = w_copy_data;
        if (r_idx == LAST_COPY) w_state_nxt = S_SCROLL_BLANK;
        w_idx_nxt = r_idx + 10'd1;
      end
      S_SCROLL_BLANK: begin
        w_we = 1'b1;
        if (r_idx == LAST_CELL) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 10'd0;
        end else begin
          w_idx_nxt = r_idx + 10'd1;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_idx_nxt   = 10'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_CLEAR;
      r_idx   <= 10'd0;
      r_row   <= 4'd0;
      r_col   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // buffer contents are left unreset; CLEAR establishes them
  always_ff @(posedge i_clk) begin
    if (w_we && !i_reset) r_mem[w_waddr] <= w_wdata;
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed and randomized checks of text_buffer_writer against a 2-D screen model.
module tb_text_buffer_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [3:0] char_row = 4'd0;
  logic [5:0] char_col = 6'd0;
  logic [7:0] character_id;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;

  int n_checks = 0;
  int n_fails  = 0;

  byte unsigned m_mem [15][40];
  int           m_row, m_col;

  text_buffer_writer dut (
    .i_clk(clk), .i_reset(reset), .i_char_in(char_in), .i_char_valid(char_valid),
    .o_char_ready(char_ready), .i_char_row(char_row), .i_char_col(char_col),
    .o_character_id(character_id), .o_cursor_row(cursor_row), .o_cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void m_clear();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 40; c++) m_mem[r][c] = 8'h20;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic bit m_advance();
    if (m_row < 14) begin
      m_row++;
      return 1'b0;
    end
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 40; c++) m_mem[r][c] = m_mem[r+1][c];
    for (int c = 0; c < 40; c++) m_mem[14][c] = 8'h20;
    return 1'b1;
  endfunction

  // returns 1 when the character should make the block busy for a full pass
  function automatic bit m_put(input byte unsigned c);
    bit busy = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_mem[m_row][m_col] = c;
      m_col++;
      if (m_col == 40) begin
        m_col = 0;
        busy  = m_advance();
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      busy  = m_advance();
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row][m_col] = 8'h20;
      end
    end else if (c == 8'h0C) begin
      m_clear();
      busy = 1'b1;
    end
    return busy;
  endfunction

  task automatic check_cursor(input string tag);
    chk({tag, " cursor_row"}, {28'd0, cursor_row}, m_row);
    chk({tag, " cursor_col"}, {26'd0, cursor_col}, m_col);
  endtask

  task automatic check_cell(input string tag, input int r, input int c, input logic [7:0] exp);
    char_row = 4'(r);
    char_col = 6'(c);
    #1;
    chk($sformatf("%s cell(%0d,%0d)", tag, r, c), {24'd0, character_id}, {24'd0, exp});
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 40; c++) check_cell(tag, r, c, m_mem[r][c]);
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (!char_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, n, 600);
  endtask

  task automatic send(input logic [7:0] c, input bit check_busy);
    int n = 0;
    bit busy;
    @(negedge clk);
    while (!char_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready before send", {31'd0, char_ready}, 1);
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk);
    busy = m_put(c);
    @(negedge clk);
    char_valid = 1'b0;
    check_cursor($sformatf("after 0x%0h", c));
    if (check_busy) begin
      if (busy) count_busy($sformatf("after 0x%0h", c));
      else chk("ready after accept", {31'd0, char_ready}, 1);
    end
  endtask

  initial begin
    int r;
    logic [7:0] c;

    // reset and initial clear
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset char_ready", {31'd0, char_ready}, 0);
    m_clear();
    check_cursor("reset");
    reset = 1'b0;
    count_busy("initial clear");
    check_all("after clear");
    check_cell("oor row", 15, 0, 8'h20);
    check_cell("oor col", 0, 40, 8'h20);
    check_cell("oor both", 15, 63, 8'h20);

    // printable and backspace
    send(8'h48, 1);
    send(8'h69, 1);
    check_cell("Hi", 0, 0, 8'h48);
    check_cell("Hi", 0, 1, 8'h69);
    send(8'h08, 1);
    check_cell("bs", 0, 1, 8'h20);
    send(8'h08, 1);
    send(8'h08, 1);
    chk("bs hold col", {26'd0, cursor_col}, 0);

    // line wrap, CR, LF
    for (int i = 0; i < 41; i++) send(8'h41, 1);
    check_cell("wrap", 1, 0, 8'h41);
    check_cell("wrap", 0, 39, 8'h41);
    send(8'h0D, 1);
    send(8'h0A, 1);
    chk("crlf row", {28'd0, cursor_row}, 2);
    check_all("after wrap");

    // scroll by newline on the last row
    send(8'h0C, 1);
    send(8'h0A, 1);
    for (int i = 0; i < 5; i++) send(8'h41, 1);
    send(8'h42, 1);
    while (m_row < 14) send(8'h0A, 1);
    send(8'h0A, 1);
    check_cell("scroll moved", 0, 5, 8'h42);
    chk("scroll row", {28'd0, cursor_row}, 14);
    check_all("after scroll");

    // scroll by wrap at (14,39)
    for (int i = 0; i < 39; i++) send(8'h43, 1);
    send(8'h44, 1);
    check_cell("corner", 13, 39, 8'h44);
    check_cell("corner blank", 14, 39, 8'h20);

    // form feed and ignored code
    send(8'h0C, 1);
    check_all("after ff");
    send(8'h07, 1);
    check_all("after bel");

    // valid held during busy: exactly one accept
    @(negedge clk);
    char_in    = 8'h0C;
    char_valid = 1'b1;
    @(posedge clk);
    void'(m_put(8'h0C));
    @(negedge clk);
    char_in = 8'h5A;
    count_busy("held ff");
    @(posedge clk);
    void'(m_put(8'h5A));
    @(negedge clk);
    char_valid = 1'b0;
    check_cursor("held Z");
    check_all("held Z");

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 68)      c = 8'($urandom_range(32, 126));
      else if (r < 80) c = 8'h0A;
      else if (r < 85) c = 8'h0D;
      else if (r < 93) c = 8'h08;
      else if (r < 98) c = 8'($urandom_range(0, 255));
      else             c = 8'h0C;
      send(c, 1);
      if (i % 25 == 24) check_all($sformatf("random %0d", i));
    end
    check_all("random end");

    // reset in the middle of a scroll
    while (m_row < 14) send(8'h0A, 1);
    send(8'h41, 1);
    send(8'h0A, 0);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid-scroll reset ready", {31'd0, char_ready}, 0);
    m_clear();
    check_cursor("mid-scroll reset");
    reset = 1'b0;
    count_busy("reclear");
    check_all("after reclear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/text_buffer_writer.md
# text_buffer_writer

Character-cell screen memory and cursor engine that feeds the VGA text pipeline. Accepts a stream of 8-bit character codes, handles printable characters, newline, carriage return, backspace and clear-screen, and stores them in a 15×40 cell buffer. On its read side it resolves the pixel encoder's `char_row`/`char_col` lookup into a `character_id`. It is the writer half of the text display: the pixel encoder reads cells, this block produces them.

## Interface

Parameters:
- `ROW_NUMBER`, 15, text lines on screen.
- `COL_NUMBER`, 40, cells per line.
- `BLANK_ID`, 8'h20, character ID written to cleared or erased cells.

Ports:
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `char_in`  input  8  incoming character code.
- `char_valid`  input  1  `char_in` is valid this cycle.
- `char_ready`  output  1  block can accept a character this cycle.
- `char_row`  input  4  display read row, driven by the pixel encoder.
- `char_col`  input  6  display read column, driven by the pixel encoder.
- `character_id`  output  8  cell contents at (`char_row`, `char_col`); combinational.
- `cursor_row`  output  4  current cursor row.
- `cursor_col`  output  6  current cursor column.

## Operation

Storage and read port:
- 600-entry × 8-bit buffer; cell address = row*40 + col (10 bits).
- Display read port is asynchronous: `character_id` = mem[char_row*40 + char_col].
- If `char_row` ≥ 15 or `char_col` ≥ 40, `character_id` = `BLANK_ID`.
- A second internal read port is used for scroll copy.

State machine: CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK.
- `char_ready` = 1 only in IDLE.

CLEAR:
- Writes `BLANK_ID` to address k for k = 0..599, one cell per cycle.
- Moves to IDLE after k = 599.
- Cursor is held at (0,0).

IDLE:
- A character is accepted on a rising edge where `char_valid` && `char_ready`.
- Printable codes 0x20–0x7E: write the code at the cursor, then col+1.
  - If col was 39, col becomes 0 and the row advances.
- 0x0A newline: col = 0, row advances.
- 0x0D carriage return: col = 0; no write.
- 0x08 backspace:
  - If col > 0: col−1 and write `BLANK_ID` at the new position.
  - If col = 0: no operation (no wrap to the previous row).
- 0x0C form feed: enter CLEAR; cursor goes to (0,0).
- All other codes are accepted and ignored.

Row advance:
- If row < 14: row+1.
- If row = 14: row stays 14 and the FSM enters SCROLL_COPY.

SCROLL_COPY:
- For i = 0..559, one per cycle: mem[i] ← mem[i+40].

SCROLL_BLANK:
- For i = 560..599: mem[i] ← `BLANK_ID`.
- Then returns to IDLE.

Counters:
- One 10-bit index counter is shared by CLEAR and the scroll states.
- Cursor col saturates within 0..39 and row within 0..14; no other values are ever reachable.

## Timing

Reset:
- Takes effect on the first rising edge with `reset` = 1.
- Outputs after reset: `char_ready` = 0, `cursor_row` = 0, `cursor_col` = 0, state = CLEAR with index 0.
- Buffer contents are undefined until CLEAR completes.
- `char_ready` rises 600 cycles after reset deasserts.

Accept and write latency:
- A printable character accepted at edge N is visible on `character_id` from just after edge N (the write happens at N).
- The cursor update is also visible after edge N.

Scroll timing:
- The accepting edge N moves the FSM into SCROLL_COPY.
- The copy runs at edges N+1..N+560, the blank at N+561..N+600.
- IDLE is reached after N+600, so `char_ready` is high from cycle N+601.
- A printable character written at (14,39) appears at (13,39) once the scroll completes.

Clear timing:
- 0x0C accepted at N: `char_ready` is low for 600 cycles.

Boundary conditions:
- Reset asserted mid-CLEAR or mid-scroll aborts immediately and restarts CLEAR from index 0 with the cursor at (0,0).
- `char_valid` held high while `char_ready` is low: no accept. The source holds the character; it is not dropped or duplicated.
- During scroll the display read port shows partially shifted contents. This is acceptable and no frame sync is applied.

## Test plan

- Reset, then wait 600 cycles: `char_ready` = 1, every readable cell = 0x20, cursor (0,0); reading (15,0) and (0,40) gives 0x20.
- Send 'H' 0x48 then 'i' 0x69: cell (0,0) = 0x48, (0,1) = 0x69, cursor (0,2). Then send 0x08: cell (0,1) = 0x20, cursor (0,1). Then send 0x08 twice: cursor (0,0) and held there.
- Send 41 × 'A' 0x41: row 0 is all 0x41, cell (1,0) = 0x41, cursor (1,1). Then send 0x0D then 0x0A: cursor (2,0).
- Fill to row 14 and send 0x0A with cell (1,5) = 0x42: `char_ready` is low for exactly 600 cycles; afterwards cell (0,5) = 0x42, row 14 is all 0x20, cursor (14,0).
- Send 0x0C after writing data: 600 cycles low `char_ready`, all cells 0x20, cursor (0,0). Send 0x07: cursor and buffer unchanged.
- Assert `reset` 100 cycles into a scroll: `char_ready` = 0 and cursor (0,0) next cycle; the buffer is fully blank 600 cycles after release.
